// File: rtl/deser_queue_pkg.sv
// Shared types and helpers for the deser_queue serial-input word queue.
package deser_queue_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PUSH    = 1'b1
  } coll_state_e;

  // Bit-order and full-queue policy encodings for MSB_FIRST / OVERWRITE.
  localparam int BIT_ORDER_MSB    = 1;
  localparam int POLICY_OVERWRITE = 1;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Read/write pointer width; pointers wrap naturally since depth is a power of two.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/deser_queue_bit_collector.sv
// Bit collector: strobe edge detection, shift register, bit counter and
// COLLECT/PUSH FSM. Emits a one-cycle push strobe with the assembled word.
// Optional macro DESER_QUEUE_SYNC_EN adds a 2-flop synchroniser on every input.
//
// state   | meaning
// COLLECT | waiting for write edges, shifting bits into the word
// PUSH    | word complete, push strobe high for one cycle
module deser_queue_bit_collector
  import deser_queue_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1,
  parameter int BW        = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              data_i,
  input  logic              write_i,
  input  logic              dequeue_i,
  output logic [DATA_W-1:0] word_o,
  output logic              push_o,
  output logic [BW-1:0]     bit_cnt_o,
  output logic              deq_edge_o
);

  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  logic data_s, write_s, deq_s;

`ifdef DESER_QUEUE_SYNC_EN
  logic [1:0] data_sync_q, write_sync_q, deq_sync_q;

  // Two-flop synchronisers; data travels with the strobes so alignment holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_sync_q  <= '0;
      write_sync_q <= '0;
      deq_sync_q   <= '0;
    end else begin
      data_sync_q  <= {data_sync_q[0], data_i};
      write_sync_q <= {write_sync_q[0], write_i};
      deq_sync_q   <= {deq_sync_q[0], dequeue_i};
    end
  end

  assign data_s  = data_sync_q[1];
  assign write_s = write_sync_q[1];
  assign deq_s   = deq_sync_q[1];
`else
  assign data_s  = data_i;
  assign write_s = write_i;
  assign deq_s   = dequeue_i;
`endif

  logic              write_q, deq_q;
  logic              wr_edge;
  coll_state_e       state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d, shifted;
  logic [BW-1:0]     cnt_q, cnt_d;

  assign wr_edge    = write_s & ~write_q;
  assign deq_edge_o = deq_s & ~deq_q;

  assign shifted = (MSB_FIRST == BIT_ORDER_MSB) ? {sr_q[DATA_W-2:0], data_s}
                                                : {data_s, sr_q[DATA_W-1:1]};

  // State, shift register, bit counter and strobe history registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= COLLECT;
      sr_q    <= '0;
      cnt_q   <= '0;
      write_q <= 1'b0;
      deq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      write_q <= write_s;
      deq_q   <= deq_s;
    end
  end

  // Next state: a write edge always shifts, even in PUSH, so no bit is lost.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      COLLECT, PUSH: begin
        state_d = COLLECT;
        if (wr_edge) begin
          sr_d = shifted;
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = PUSH;
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign word_o    = sr_q;
  assign push_o    = (state_q == PUSH);
  assign bit_cnt_o = cnt_q;

endmodule

// File: rtl/deser_queue.sv
// Serial-to-parallel receiver feeding a DEPTH-entry first-word-fall-through
// queue with full/empty/occupancy/overflow reporting.
// Optional macro DESER_QUEUE_SYNC_EN (handled in the collector) synchronises inputs.
module deser_queue
  import deser_queue_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int OVERWRITE = 0
) (
  input  logic                       clock1M,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       dequeue_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       status_out,
  output logic                       empty_out,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic [$clog2(DATA_W)-1:0]  bit_cnt_out,
  output logic                       overflow_out
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DATA_W-1:0] word;
  logic              push, deq_edge, pop, full, empty, wr_en;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  deser_queue_bit_collector #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_bit_collector (
    .clk_i      (clock1M),
    .rst_ni     (reset),
    .data_i     (data_in),
    .write_i    (write_in),
    .dequeue_i  (dequeue_in),
    .word_o     (word),
    .push_o     (push),
    .bit_cnt_o  (bit_cnt_out),
    .deq_edge_o (deq_edge)
  );

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = deq_edge & ~empty;

  // Pointer/count/overflow update; a pop in the same cycle frees room for the push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    if (push) begin
      if (pop) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else if (!full) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        count_d  = count_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
        if (OVERWRITE == POLICY_OVERWRITE) begin
          // Full means wr_ptr == rd_ptr: overwrite the oldest and move head on.
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
      end
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d  = count_q - CW'(1);
    end
  end

  // Queue control registers.
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: data_out is forced to zero while empty.
  always_ff @(posedge clock1M) begin
    if (wr_en) mem_q[wr_ptr_q] <= word;
  end

  assign data_out     = empty ? '0 : mem_q[rd_ptr_q];
  assign status_out   = full;
  assign empty_out    = empty;
  assign count_out    = count_q;
  assign overflow_out = ovf_q;

endmodule
